// File: rtl/rop3_pkg.sv
// Shared types and constants for the ROP3 streaming engine.
package rop3_pkg;

    // Beat sequencing: three load beats, then the result hand-off.
    typedef enum logic [1:0] {
        LOAD_P = 2'd0,
        LOAD_S = 2'd1,
        LOAD_D = 2'd2,
        OUT    = 2'd3
    } state_t;

    // Common raster-operation codes. Every 8-bit value is a legal code;
    // these names only document the usual ones.
    localparam logic [7:0] ROP_BLACKNESS   = 8'h00;
    localparam logic [7:0] ROP_NOTSRCERASE = 8'h11;
    localparam logic [7:0] ROP_NOTSRCCOPY  = 8'h33;
    localparam logic [7:0] ROP_SRCERASE    = 8'h44;
    localparam logic [7:0] ROP_DSTINVERT   = 8'h55;
    localparam logic [7:0] ROP_PATINVERT   = 8'h5A;
    localparam logic [7:0] ROP_SRCINVERT   = 8'h66;
    localparam logic [7:0] ROP_SRCAND      = 8'h88;
    localparam logic [7:0] ROP_MERGEPAINT  = 8'hBB;
    localparam logic [7:0] ROP_MERGECOPY   = 8'hC0;
    localparam logic [7:0] ROP_SRCCOPY     = 8'hCC;
    localparam logic [7:0] ROP_SRCPAINT    = 8'hEE;
    localparam logic [7:0] ROP_PATCOPY     = 8'hF0;
    localparam logic [7:0] ROP_PATPAINT    = 8'hFB;
    localparam logic [7:0] ROP_WHITENESS   = 8'hFF;

    // One bit of a ternary ROP: the code is an 8-entry truth table
    // indexed by {pattern, source, destination}.
    function automatic logic rop3_bit(input logic [7:0] mode,
                                      input logic       p,
                                      input logic       s,
                                      input logic       d);
        return mode[{p, s, d}];
    endfunction

endpackage

// File: rtl/rop3_ctrl.sv
// Control path: beat sequencing, input/output handshakes and the
// completed-operation counter. Emits one load strobe per beat type.
module rop3_ctrl
    import rop3_pkg::*;
#(
    parameter int CNT_W = 8
) (
    input  logic             clk,
    input  logic             srst_n,
    input  logic             i_flush,
    input  logic             i_in_valid,
    input  logic             i_out_ready,
    output logic             o_in_ready,
    output logic             o_out_valid,
    output logic [CNT_W-1:0] o_op_cnt,
    output logic             o_load_p,
    output logic             o_load_s,
    output logic             o_load_d
);

    state_t           r_state;
    state_t           w_state_nxt;
    logic             r_out_valid;
    logic [CNT_W-1:0] r_op_cnt;
    logic             w_accept;
    logic             w_handoff;

    // in_ready depends on state only, so it never combinationally
    // follows in_valid or out_ready.
    assign o_in_ready = (r_state != OUT);
    assign w_accept   = i_in_valid & o_in_ready;
    assign w_handoff  = r_out_valid & i_out_ready;

    // A flushed beat must not reach the datapath.
    assign o_load_p = !i_flush && w_accept && (r_state == LOAD_P);
    assign o_load_s = !i_flush && w_accept && (r_state == LOAD_S);
    assign o_load_d = !i_flush && w_accept && (r_state == LOAD_D);

    assign o_out_valid = r_out_valid;
    assign o_op_cnt    = r_op_cnt;

    // Next-state decode; flush overrides every other transition.
    always_comb begin
        // NOTE: default first so every path assigns the variable and no latch is inferred.
        w_state_nxt = r_state;
        if (i_flush) begin
            w_state_nxt = LOAD_P;
        end else begin
            case (r_state)
                LOAD_P:  if (w_accept)    w_state_nxt = LOAD_S;
                LOAD_S:  if (w_accept)    w_state_nxt = LOAD_D;
                LOAD_D:  if (w_accept)    w_state_nxt = OUT;
                OUT:     if (i_out_ready) w_state_nxt = LOAD_P;
                default:                  w_state_nxt = LOAD_P;
            endcase
        end
    end

    // State, output-valid flag and hand-off counter.
    always_ff @(posedge clk or negedge srst_n) begin
        if (!srst_n) begin
            // NOTE: non-blocking assignments for all clocked state so every register samples pre-edge values.
            r_state     <= LOAD_P;
            r_out_valid <= 1'b0;
            r_op_cnt    <= '0;
        end else begin
            r_state <= w_state_nxt;
            if (i_flush) begin
                r_out_valid <= 1'b0;
            end else if (o_load_d) begin
                r_out_valid <= 1'b1;
            end else if (w_handoff) begin
                r_out_valid <= 1'b0;
            end
            if (!i_flush && w_handoff) begin
                r_op_cnt <= r_op_cnt + 1'b1;
            end
        end
    end

endmodule

// File: rtl/rop3_stream.sv
// Streaming ternary raster-operation engine. Collects P, S, D beats and
// evaluates the latched 8-bit ROP3 code per bit through a lookup mux.
module rop3_stream
    import rop3_pkg::*;
#(
    parameter int N     = 8,
    parameter int CNT_W = 8
) (
    input  logic             clk,
    input  logic             srst_n,
    input  logic             flush,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [N-1:0]     Bitmap,
    input  logic [7:0]       Mode,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [N-1:0]     Result,
    output logic [CNT_W-1:0] op_cnt
);

    logic [N-1:0] r_p;
    logic [N-1:0] r_s;
    logic [7:0]   r_m;
    logic [N-1:0] r_result;
    logic [N-1:0] w_rop;
    logic         w_load_p;
    logic         w_load_s;
    logic         w_load_d;

    rop3_ctrl #(
        .CNT_W (CNT_W)
    ) u_ctrl (
        .clk         (clk),
        .srst_n      (srst_n),
        .i_flush     (flush),
        .i_in_valid  (in_valid),
        .i_out_ready (out_ready),
        .o_in_ready  (in_ready),
        .o_out_valid (out_valid),
        .o_op_cnt    (op_cnt),
        .o_load_p    (w_load_p),
        .o_load_s    (w_load_s),
        .o_load_d    (w_load_d)
    );

    // D is consumed straight off the bus on its beat, so it needs no
    // holding register; the result register captures it instead.
    for (genvar gi = 0; gi < N; gi++) begin : g_lut
        assign w_rop[gi] = rop3_bit(r_m, r_p[gi], r_s[gi], Bitmap[gi]);
    end

    // Operand, mode and result registers, each loaded on its own beat.
    always_ff @(posedge clk or negedge srst_n) begin
        if (!srst_n) begin
            // NOTE: datapath registers are reset too, so Result reads 0 straight out of reset.
            r_p      <= '0;
            r_s      <= '0;
            r_m      <= '0;
            r_result <= '0;
        end else begin
            if (w_load_p) begin
                r_p <= Bitmap;
                r_m <= Mode;
            end
            if (w_load_s) begin
                r_s <= Bitmap;
            end
            if (w_load_d) begin
                r_result <= w_rop;
            end
        end
    end

    assign Result = r_result;

endmodule

// File: tb/tb_rop3_stream.sv
// Directed bench for rop3_stream. Two instances (N=8/CNT_W=2 and
// N=16/CNT_W=8) run the same stimulus in lockstep against one
// behavioural model; directed literals pin the model.
module tb_rop3_stream;

    logic        clk = 1'b0;
    logic        srst_n;
    logic        flush;
    logic        in_valid;
    logic [15:0] bitmap;
    logic [7:0]  mode;
    logic        out_ready;

    logic        rdy8, vld8, rdy16, vld16;
    logic [7:0]  res8;
    logic [15:0] res16;
    logic [1:0]  cnt8;
    logic [7:0]  cnt16;

    int n_vec = 0;
    int n_err = 0;
    bit chk_en = 1'b0;

    always #5 clk = ~clk;

    rop3_stream #(.N(8), .CNT_W(2)) u_dut8 (
        .clk       (clk),
        .srst_n    (srst_n),
        .flush     (flush),
        .in_valid  (in_valid),
        .in_ready  (rdy8),
        .Bitmap    (bitmap[7:0]),
        .Mode      (mode),
        .out_valid (vld8),
        .out_ready (out_ready),
        .Result    (res8),
        .op_cnt    (cnt8)
    );

    rop3_stream #(.N(16), .CNT_W(8)) u_dut16 (
        .clk       (clk),
        .srst_n    (srst_n),
        .flush     (flush),
        .in_valid  (in_valid),
        .in_ready  (rdy16),
        .Bitmap    (bitmap),
        .Mode      (mode),
        .out_valid (vld16),
        .out_ready (out_ready),
        .Result    (res16),
        .op_cnt    (cnt16)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // ---------------- behavioural model ----------------
    // Truth-table definition: bit i of the result is bit number
    // (4*P[i] + 2*S[i] + D[i]) of the mode byte.
    function automatic logic [15:0] rop_model(input logic [7:0] m, input logic [15:0] p,
                                              input logic [15:0] s, input logic [15:0] d);
        logic [15:0] r;
        for (int i = 0; i < 16; i++) begin
            int idx;
            idx  = 4 * int'(p[i]) + 2 * int'(s[i]) + int'(d[i]);
            r[i] = m[idx];
        end
        return r;
    endfunction

    int          m_beats;   // beats of the current triple received so far
    bit          m_pending; // a result is waiting for hand-off
    logic [15:0] m_p, m_s, m_res;
    logic [7:0]  m_m;
    int          m_done;    // completed hand-offs since reset

    always @(posedge clk or negedge srst_n) begin
        if (!srst_n) begin
            m_beats = 0; m_pending = 0; m_p = '0; m_s = '0; m_m = '0; m_res = '0; m_done = 0;
        end else if (flush) begin
            m_beats = 0; m_pending = 0;
        end else if (m_pending) begin
            if (out_ready) begin
                m_pending = 0;
                m_done++;
            end
        end else if (in_valid) begin
            if (m_beats == 0) begin
                m_p = bitmap; m_m = mode; m_beats = 1;
            end else if (m_beats == 1) begin
                m_s = bitmap; m_beats = 2;
            end else begin
                m_res = rop_model(m_m, m_p, m_s, bitmap);
                m_pending = 1; m_beats = 0;
            end
        end
    end

    // Per-cycle compare, away from the active edge.
    always @(negedge clk) begin
        if (chk_en) begin
            logic [31:0] done32;
            done32 = m_done;
            check("vld16", vld16, m_pending);
            check("vld8", vld8, m_pending);
            check("rdy16", rdy16, !m_pending);
            check("rdy8", rdy8, !m_pending);
            check("cnt16", cnt16, done32[7:0]);
            check("cnt8", cnt8, done32[1:0]);
            if (m_pending) begin
                check("res16", res16, m_res);
                check("res8", res8, m_res[7:0]);
            end
        end
    end

    // ---------------- stimulus ----------------
    task automatic beat(input logic [15:0] b, input logic [7:0] m);
        int t;
        t = 0;
        @(negedge clk);
        while (!rdy16 && t < 50) begin
            @(negedge clk);
            t++;
        end
        if (t >= 50) check("beat_timeout", 32'd0, 32'd1);
        #1;
        in_valid = 1'b1; bitmap = b; mode = m;
        @(posedge clk);
        #1 in_valid = 1'b0;
    endtask

    // Mode on S and D beats is deliberately junk: it must be ignored.
    task automatic triple(input logic [7:0] m, input logic [15:0] p,
                          input logic [15:0] s, input logic [15:0] d);
        beat(p, m);
        beat(s, 8'h11);
        beat(d, 8'h22);
    endtask

    logic [1:0] wrap_exp [5];

    initial begin
        wrap_exp = '{2'd1, 2'd2, 2'd3, 2'd0, 2'd1};
        srst_n = 1'b0; flush = 1'b0; in_valid = 1'b0; bitmap = '0; mode = '0; out_ready = 1'b1;
        repeat (2) @(negedge clk);
        check("rst_res16", res16, 16'h0000);
        check("rst_vld16", vld16, 1'b0);
        #1 srst_n = 1'b1;
        chk_en = 1'b1;
        @(negedge clk);
        check("rst_rdy16", rdy16, 1'b1);
        check("rst_cnt16", cnt16, 8'd0);

        // Pattern copy.
        triple(8'hF0, 16'h00A5, 16'h003C, 16'h000F);
        @(negedge clk);
        check("patcopy_vld", vld8, 1'b1);
        check("patcopy_res", res8, 8'hA5);
        @(negedge clk);
        check("patcopy_cnt", cnt16, 8'd1);

        // Three-way XOR and P^D.
        triple(8'h96, 16'h00FF, 16'h000F, 16'h0033);
        @(negedge clk);
        check("xor3_res", res8, 8'hC3);
        triple(8'h5A, 16'h00FF, 16'h000F, 16'h0033);
        @(negedge clk);
        check("patinv_res", res8, 8'hCC);
        @(negedge clk);
        check("patinv_cnt", cnt16, 8'd3);

        // Backpressure: result held for 5 cycles.
        out_ready = 1'b0;
        triple(8'h96, 16'h00FF, 16'h000F, 16'h0033);
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            check("bp_vld", vld8, 1'b1);
            check("bp_res", res8, 8'hC3);
            check("bp_rdy", rdy8, 1'b0);
        end
        #1 out_ready = 1'b1;
        @(negedge clk);
        check("bp_vld_after", vld8, 1'b0);
        check("bp_cnt", cnt16, 8'd4);

        // Flush during LOAD_S discards the beat presented with it.
        beat(16'h00FF, 8'hF0);
        @(negedge clk);
        #1 in_valid = 1'b1; bitmap = 16'h0077; flush = 1'b1;
        @(posedge clk);
        #1 in_valid = 1'b0; flush = 1'b0;
        triple(8'hCC, 16'h0012, 16'h005E, 16'h0099);
        @(negedge clk);
        check("flush_res", res8, 8'h5E);
        @(negedge clk);
        check("flush_cnt", cnt16, 8'd5);

        // Asynchronous reset in the OUT state.
        out_ready = 1'b0;
        triple(8'hFF, 16'h0000, 16'h0000, 16'h0000);
        @(negedge clk);
        check("pre_rst_vld", vld16, 1'b1);
        #3 srst_n = 1'b0;
        #1;
        check("async_vld16", vld16, 1'b0);
        check("async_vld8", vld8, 1'b0);
        check("async_res16", res16, 16'h0000);
        check("async_res8", res8, 8'h00);
        @(negedge clk);
        #1 srst_n = 1'b1; out_ready = 1'b1;
        @(negedge clk);
        check("post_rst_rdy", rdy8, 1'b1);

        // Counter wrap on the CNT_W=2 instance.
        for (int k = 0; k < 5; k++) begin
            triple(8'h00, 16'hA5A5, 16'h3C3C, 16'hFFFF);
            @(negedge clk);
            check("black_res", res16, 16'h0000);
            @(negedge clk);
            check("wrap_cnt8", cnt8, wrap_exp[k]);
        end
        check("wrap_cnt16", cnt16, 8'd5);

        // Full 16-bit source paint.
        triple(8'hEE, 16'h1234, 16'h00F0, 16'h0F00);
        @(negedge clk);
        check("srcpaint_res16", res16, 16'h0FF0);
        @(negedge clk);
        check("srcpaint_cnt16", cnt16, 8'd6);

        chk_en = 1'b0;
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

endmodule

// File: doc/rop3_stream.md
# rop3_stream

Streaming ternary raster-operation engine, parametrised in bitmap width. It accepts Pattern, Source and Destination bitmaps as three consecutive beats on a valid/ready input channel and evaluates any of the 256 ROP3 codes per bit through an 8-entry truth-table lookup. It returns the result on a valid/ready output channel with backpressure. It is the general-mode successor to the fixed 15-mode ROP3 unit and sits between the bitmap fetch stage and the write-back stage.

## Interface
- N, 8: bitmap width in bits (≥1)
- CNT_W, 8: width of completed-operation counter
- clk  in  1  clock, rising edge
- srst_n  in  1  reset, asynchronous assert, active-low
- flush  in  1  synchronous abort of the current triple
- in_valid  in  1  input beat valid
- in_ready  out  1  engine accepts a beat
- Bitmap  in  N  beat data: P, then S, then D
- Mode  in  8  ROP3 code, sampled on the P beat only
- out_valid  out  1  Result valid
- out_ready  in  1  downstream accepts Result
- Result  out  N  operation result
- op_cnt  out  CNT_W  completed (handed-off) operations, wraps

## Operation
- Per-bit function: Result[i] = M[{P[i], S[i], D[i]}], where M is the latched Mode. Examples: 0xF0=P, 0xCC=S, 0xAA=D, 0x96=P^S^D, 0x00=0, 0xFF=all ones.
- All 256 codes are valid. No default-to-zero case.
- State machine:
  - LOAD_P: in_ready=1. On accept, P←Bitmap, M←Mode, go to LOAD_S.
  - LOAD_S: in_ready=1. On accept, S←Bitmap, go to LOAD_D.
  - LOAD_D: in_ready=1. On accept, Result←f(M,P,S,Bitmap), out_valid←1, go to OUT.
  - OUT: in_ready=0. When out_ready=1, out_valid←0, op_cnt←op_cnt+1 mod 2^CNT_W, go to LOAD_P.
- A state advances only on accept (in_valid & in_ready). With no accept, the state and registers hold.
- Mode on S and D beats is ignored.
- flush=1 in any state: next state LOAD_P, out_valid←0, op_cnt unchanged. Any beat presented the same cycle is discarded. flush takes priority over accept and over the output handshake.
- Result is registered and stays stable while out_valid=1 and out_ready=0.
- Reset values: state=LOAD_P, P=S=D=M=0, Result=0, out_valid=0, op_cnt=0. in_ready=1 once reset deasserts.

## Timing
- in_ready is a Moore output, decoded from state only.
- Latency: D accepted at edge k, so out_valid=1 and Result valid from edge k onward (one cycle after the D beat is presented).
- Maximum throughput: 4 cycles per operation with continuous in_valid and out_ready=1 (3 load beats plus 1 OUT cycle).
- op_cnt increments at the edge where out_valid & out_ready & !flush.
- Reset asserted mid-operation clears everything immediately, without waiting for a clock edge. Recovery starts in LOAD_P.

## Structure
- Package rop3_pkg holds:
  - state enum {LOAD_P, LOAD_S, LOAD_D, OUT}, 2 bits
  - ROP code constants (ROP_BLACKNESS 0x00, ROP_SRCCOPY 0xCC, ROP_PATCOPY 0xF0, ROP_SRCINVERT 0x66, ROP_WHITENESS 0xFF, ...)
- Sub-module rop3_ctrl holds the state register, next-state logic, in_ready, out_valid and op_cnt.
- The top level holds the datapath registers and the generate loop of N 8:1 lookup muxes.

## Test plan
- N=8, Mode=0xF0, P=0xA5, S=0x3C, D=0x0F, out_ready=1 → Result=0xA5 one cycle after the D beat. op_cnt=1 after the handoff.
- N=8, Mode=0x96, P=0xFF, S=0x0F, D=0x33 → Result=0xC3. Also cover Mode=0x5A with the same data → Result=0xCC.
- Backpressure: out_ready=0 for 5 cycles after the D beat → out_valid and Result=0xC3 held, in_ready=0. The handoff happens on the first out_ready=1 cycle.
- Flush during LOAD_S with in_valid=1 → that beat is discarded. The next triple (Mode=0xCC, S=0x5E) yields 0x5E, and op_cnt counts only the completed operation.
- Reset asserted mid-cycle in OUT → out_valid=0 and Result=0 immediately, and in_ready=1 after release. N=16, Mode=0xEE, S=0x00F0, D=0x0F00 → 0x0FF0.
- CNT_W=2: run 5 back-to-back operations with Mode=0x00 → op_cnt sequence 1,2,3,0,1. Every Result=0.
